// File: rtl/cpu_pkg.sv
// Shared constants for the memory-mapped I/O peripheral: register offsets,
// CTRL bit positions and the default base address of the register window.
package cpu_pkg;

  localparam logic [15:0] DEFAULT_BASE = 16'hFF00;

  localparam logic [3:0] OFF_OUT0   = 4'd0;
  localparam logic [3:0] OFF_OUT1   = 4'd1;
  localparam logic [3:0] OFF_OUT2   = 4'd2;
  localparam logic [3:0] OFF_OUT3   = 4'd3;
  localparam logic [3:0] OFF_IN0    = 4'd4;
  localparam logic [3:0] OFF_IN1    = 4'd5;
  localparam logic [3:0] OFF_IN2    = 4'd6;
  localparam logic [3:0] OFF_IN3    = 4'd7;
  localparam logic [3:0] OFF_RELOAD = 4'd8;
  localparam logic [3:0] OFF_CTRL   = 4'd9;
  localparam logic [3:0] OFF_COUNT  = 4'd10;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_IE  = 1;
  localparam int CTRL_EXP = 15;

  // Assemble the CTRL read-back word; unused bits read as zero.
  function automatic logic [15:0] ctrl_word(input logic en, input logic ie, input logic expd);
    ctrl_word = {expd, 13'd0, ie, en};
  endfunction

endpackage

// File: rtl/io_periph_if.sv
// CPU-side bus of the I/O peripheral: address, write data, strobes and the
// registered read return path.
interface io_periph_if;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] rdata;
  logic        rvalid;

  modport master (output addr, output wdata, output wr_en, output rd_en,
                  input rdata, input rvalid);
  modport slave  (input addr, input wdata, input wr_en, input rd_en,
                  output rdata, output rvalid);
endinterface

// File: rtl/io_timer.sv
// Reloadable down-count timer: prescaler, COUNT, RELOAD and CTRL (EN/IE/EXP).
// Only instantiated when IO_PERIPH_TIMER_EN is defined.
module io_timer import cpu_pkg::*; #(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reload_we_i,
  input  logic        ctrl_we_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] count_o,
  output logic [15:0] reload_o,
  output logic [15:0] ctrl_o,
  output logic        irq_o
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   reload_q, reload_d;
  logic          en_q, en_d;
  logic          ie_q, ie_d;
  logic          exp_q, exp_d;
  logic          tick_s;

  // Next state: prescaler wrap produces a tick; an expiry set is applied
  // after the software clear so that a same-cycle set wins.
  always_comb begin
    pre_d    = pre_q;
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    ie_d     = ie_q;
    exp_d    = exp_q;
    tick_s   = 1'b0;

    if (reload_we_i || !en_q) begin
      pre_d = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d  = '0;
      tick_s = 1'b1;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    if (ctrl_we_i) begin
      en_d = wdata_i[CTRL_EN];
      ie_d = wdata_i[CTRL_IE];
      if (wdata_i[CTRL_EXP]) begin
        exp_d = 1'b0;
      end else begin
        exp_d = exp_q;
      end
    end else begin
      en_d = en_q;
    end

    if (reload_we_i) begin
      reload_d = wdata_i;
      count_d  = wdata_i;
    end else if (tick_s) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        count_d = reload_q;
        exp_d   = 1'b1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q    <= '0;
      count_q  <= 16'd0;
      reload_q <= 16'd0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      exp_q    <= exp_d;
    end
  end

  assign count_o  = count_q;
  assign reload_o = reload_q;
  assign ctrl_o   = ctrl_word(en_q, ie_q, exp_q);
  assign irq_o    = exp_q & ie_q;

endmodule

// File: rtl/io_periph.sv
// Memory-mapped I/O peripheral: 16-word window at BASE with four output port
// registers, four 2-flop synchronized input ports and, when the macro
// IO_PERIPH_TIMER_EN is defined, a reloadable down-count timer with irq.
module io_periph import cpu_pkg::*; #(
  parameter logic [15:0] BASE     = DEFAULT_BASE,
  parameter int          PRESCALE = 16,
  parameter int          NPORT    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  io_periph_if.slave           bus,
  output logic [16*NPORT-1:0]  out_port,
  input  logic [16*NPORT-1:0]  in_port,
  output logic                 irq
);

  logic        hit_s, wr_s, rd_s;
  logic [3:0]  off_s;
  logic [15:0] rd_mux_s;
  logic [15:0] rdata_q;
  logic        rvalid_q;
  logic [15:0] out_q   [NPORT];
  logic [15:0] sync1_q [NPORT];
  logic [15:0] sync2_q [NPORT];

  assign hit_s = (bus.addr[15:4] == BASE[15:4]);
  assign off_s = bus.addr[3:0];
  assign wr_s  = bus.wr_en && hit_s;
  assign rd_s  = bus.rd_en && hit_s;

`ifdef IO_PERIPH_TIMER_EN
  logic [15:0] count_s, reload_s, ctrl_s;

  io_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .reload_we_i (wr_s && (off_s == OFF_RELOAD)),
    .ctrl_we_i   (wr_s && (off_s == OFF_CTRL)),
    .wdata_i     (bus.wdata),
    .count_o     (count_s),
    .reload_o    (reload_s),
    .ctrl_o      (ctrl_s),
    .irq_o       (irq)
  );
`else
  assign irq = 1'b0;
`endif

  // Read mux over the current (pre-write) register contents.
  always_comb begin
    rd_mux_s = 16'd0;
    case (off_s)
      OFF_OUT0, OFF_OUT1, OFF_OUT2, OFF_OUT3: rd_mux_s = out_q[off_s[1:0]];
      OFF_IN0, OFF_IN1, OFF_IN2, OFF_IN3:     rd_mux_s = sync2_q[off_s[1:0]];
`ifdef IO_PERIPH_TIMER_EN
      OFF_RELOAD:                             rd_mux_s = reload_s;
      OFF_CTRL:                               rd_mux_s = ctrl_s;
      OFF_COUNT:                              rd_mux_s = count_s;
`endif
      default:                                rd_mux_s = 16'd0;
    endcase
  end

  // Output port registers, written at offsets 0-3 only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPORT; i++) out_q[i] <= 16'd0;
    end else if (wr_s && (off_s[3:2] == 2'b00)) begin
      out_q[off_s[1:0]] <= bus.wdata;
    end
  end

  // Two-flop synchronizers for the asynchronous input ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPORT; i++) begin
        sync1_q[i] <= 16'd0;
        sync2_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        sync1_q[i] <= in_port[16*i +: 16];
        sync2_q[i] <= sync1_q[i];
      end
    end
  end

  // Registered read return: one-cycle rvalid pulse, rdata holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q  <= 16'd0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_s;
      if (rd_s) rdata_q <= rd_mux_s;
    end
  end

  for (genvar n = 0; n < NPORT; n++) begin : g_out
    assign out_port[16*n +: 16] = out_q[n];
  end

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_io_periph.sv
// Directed self-checking bench for io_periph (PRESCALE = 16). Timer scenarios
// are built when IO_PERIPH_TIMER_EN is defined, otherwise the disabled-timer
// behaviour is checked.
module tb_io_periph;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] out_port;
  logic [63:0] in_port = 64'd0;
  logic        irq;
  int          n_checks = 0;
  int          n_fail = 0;

  io_periph_if bus();

  io_periph #(.BASE(16'hFF00), .PRESCALE(16), .NPORT(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port),
    .in_port  (in_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.wdata = d; bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic v, output logic [15:0] d);
    @(negedge clk);
    bus.addr = a; bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    v = bus.rvalid; d = bus.rdata;
  endtask

  task automatic test_reset();
    logic v; logic [15:0] d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_port !== 64'd0) begin n_fail++; $display("FAIL reset_out_port: got %h expected 0", out_port); end
    n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    reset = 1'b1;
    for (int o = 0; o <= 10; o++) begin
      rd(16'hFF00 + 16'(o), v, d);
      n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_read_rvalid off %0d: got %b expected 1", o, v); end
      n_checks++; if (d !== 16'd0) begin n_fail++; $display("FAIL reset_read_data off %0d: got %h expected 0", o, d); end
    end
    @(negedge clk);
    n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse: got %b expected 0", bus.rvalid); end
  endtask

  task automatic test_out_ports();
    logic v; logic [15:0] d;
    wr(16'hFF02, 16'hA5A5);
    n_checks++; if (out_port[47:32] !== 16'hA5A5) begin n_fail++; $display("FAIL out2_write: got %h expected a5a5", out_port[47:32]); end
    rd(16'hFF02, v, d);
    n_checks++; if (v !== 1'b1 || d !== 16'hA5A5) begin n_fail++; $display("FAIL out2_read: got v=%b %h expected v=1 a5a5", v, d); end
    wr(16'hFF00, 16'h1111); wr(16'hFF01, 16'h2222); wr(16'hFF03, 16'h4444);
    n_checks++; if (out_port !== 64'h4444_A5A5_2222_1111) begin n_fail++; $display("FAIL out_all: got %h expected 4444a5a522221111", out_port); end
    wr(16'hFE02, 16'h0F0F);
    n_checks++; if (out_port[47:32] !== 16'hA5A5) begin n_fail++; $display("FAIL miss_write: got %h expected a5a5", out_port[47:32]); end
    rd(16'hFE02, v, d);
    n_checks++; if (v !== 1'b0) begin n_fail++; $display("FAIL miss_read_rvalid: got %b expected 0", v); end
    n_checks++; if (d !== 16'hA5A5) begin n_fail++; $display("FAIL rdata_hold: got %h expected a5a5", d); end
    wr(16'hFF0B, 16'h1234);
    rd(16'hFF0B, v, d);
    n_checks++; if (v !== 1'b1 || d !== 16'd0) begin n_fail++; $display("FAIL reserved_read: got v=%b %h expected v=1 0", v, d); end
  endtask

  task automatic test_inputs();
    logic v; logic [15:0] d;
    @(negedge clk);
    in_port[15:0] = 16'h1234; in_port[63:48] = 16'hBEEF;
    repeat (2) @(negedge clk);
    rd(16'hFF04, v, d);
    n_checks++; if (v !== 1'b1 || d !== 16'h1234) begin n_fail++; $display("FAIL in0_read: got v=%b %h expected v=1 1234", v, d); end
    wr(16'hFF04, 16'hFFFF);
    rd(16'hFF04, v, d);
    n_checks++; if (d !== 16'h1234) begin n_fail++; $display("FAIL in0_readonly: got %h expected 1234", d); end
    rd(16'hFF07, v, d);
    n_checks++; if (d !== 16'hBEEF) begin n_fail++; $display("FAIL in3_read: got %h expected beef", d); end
  endtask

`ifdef IO_PERIPH_TIMER_EN
  task automatic test_timer();
    logic v; logic [15:0] d;
    logic [15:0] exp_cnt [4] = '{16'd3, 16'd2, 16'd1, 16'd0};
    wr(16'hFF08, 16'd3);
    wr(16'hFF09, 16'h0003);               // EN/IE commit at edge E0
    repeat (6) @(negedge clk);
    for (int k = 0; k < 4; k++) begin     // samples at E0+8+16k
      if (k != 0) repeat (14) @(negedge clk);
      rd(16'hFF0A, v, d);
      n_checks++; if (d !== exp_cnt[k]) begin n_fail++; $display("FAIL count_step %0d: got %0d expected %0d", k, d, exp_cnt[k]); end
    end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_before_expiry: got %b expected 0", irq); end
    repeat (14) @(negedge clk);
    rd(16'hFF0A, v, d);
    n_checks++; if (d !== 16'd3) begin n_fail++; $display("FAIL count_autoreload: got %0d expected 3", d); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_on_expiry: got %b expected 1", irq); end
    rd(16'hFF09, v, d);
    n_checks++; if (d !== 16'h8003) begin n_fail++; $display("FAIL ctrl_exp_read: got %h expected 8003", d); end
    wr(16'hFF09, 16'h8003);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL exp_clear: got %b expected 0", irq); end
  endtask

  task automatic test_exp_race();
    logic v; logic [15:0] d;
    wr(16'hFF08, 16'd0);                  // commit R, ticks at R+16k
    repeat (20) @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reload0_expiry: got %b expected 1", irq); end
    wr(16'hFF09, 16'h8003);               // clear at R+22, not a tick
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL exp_clear_quiet: got %b expected 0", irq); end
    repeat (8) @(negedge clk);
    wr(16'hFF09, 16'h8003);               // clear at R+32, same edge as tick
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL exp_set_wins: got %b expected 1", irq); end
    rd(16'hFF09, v, d);
    n_checks++; if (d !== 16'h8003) begin n_fail++; $display("FAIL exp_set_wins_ctrl: got %h expected 8003", d); end
  endtask
`else
  task automatic test_timer_disabled();
    logic v; logic [15:0] d;
    wr(16'hFF08, 16'h1234); wr(16'hFF09, 16'h0003); wr(16'hFF0A, 16'h0055);
    for (int o = 8; o <= 10; o++) begin
      rd(16'hFF00 + 16'(o), v, d);
      n_checks++; if (v !== 1'b1 || d !== 16'd0) begin n_fail++; $display("FAIL notimer_read off %0d: got v=%b %h expected v=1 0", o, v, d); end
    end
    repeat (40) @(negedge clk);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL notimer_irq: got %b expected 0", irq); end
  endtask
`endif

  task automatic test_rw_same_cycle();
    logic v; logic [15:0] d;
    wr(16'hFF00, 16'd5);
    @(negedge clk);
    bus.addr = 16'hFF00; bus.wdata = 16'd7; bus.rd_en = 1'b1; bus.wr_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    n_checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== 16'd5) begin n_fail++; $display("FAIL rw_old_value: got v=%b %h expected v=1 0005", bus.rvalid, bus.rdata); end
    n_checks++; if (out_port[15:0] !== 16'd7) begin n_fail++; $display("FAIL rw_write: got %h expected 0007", out_port[15:0]); end
    rd(16'hFF00, v, d);
    n_checks++; if (d !== 16'd7) begin n_fail++; $display("FAIL rw_readback: got %h expected 0007", d); end
  endtask

  task automatic test_reset_mid();
    logic v; logic [15:0] d;
`ifdef IO_PERIPH_TIMER_EN
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
`endif
    @(negedge clk);
    bus.addr = 16'hFF00; bus.rd_en = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rvalid: got %b expected 1", bus.rvalid); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.rvalid !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got rvalid=%b irq=%b expected 0 0", bus.rvalid, irq); end
    n_checks++; if (out_port !== 64'd0 || bus.rdata !== 16'd0) begin n_fail++; $display("FAIL async_reset_data: got %h %h expected 0 0", out_port, bus.rdata); end
    bus.rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rd(16'hFF0A, v, d);
    n_checks++; if (v !== 1'b1 || d !== 16'd0) begin n_fail++; $display("FAIL post_reset_count: got v=%b %h expected v=1 0", v, d); end
    rd(16'hFF09, v, d);
    n_checks++; if (d !== 16'd0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h expected 0", d); end
    rd(16'hFF02, v, d);
    n_checks++; if (v !== 1'b1 || d !== 16'd0) begin n_fail++; $display("FAIL post_reset_out2: got v=%b %h expected v=1 0", v, d); end
  endtask

  // Test sequence.
  initial begin
    bus.addr = 16'd0; bus.wdata = 16'd0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    test_reset();
    test_out_ports();
    test_inputs();
`ifdef IO_PERIPH_TIMER_EN
    test_timer();
    test_exp_race();
`else
    test_timer_disabled();
`endif
    test_rw_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_periph.md
Name: io_periph

Overview:
Memory-mapped I/O peripheral on the CPU's 16-bit address/data bus.
It consumes the address, write data and read/write strobes from the datapath, and returns read data to the datapath's data input mux.
It provides 4 output port registers, 4 synchronized input ports, and a reloadable down-count timer with an interrupt request.

Parameters:
BASE, 16'hFF00, base address of the register window (16 words; bits 3:0 are the offset)
PRESCALE, 16, number of clk cycles per timer tick; must be >= 1
NPORT, 4, number of output ports and number of input ports; fixed at 4

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
addr  in  16  bus address from the datapath
wr_en  in  1  write strobe, one cycle per access
rd_en  in  1  read strobe, one cycle per access
wdata  in  16  write data
rdata  out  16  registered read data
rvalid  out  1  one-cycle pulse marking rdata valid
out_port  out  64  4 x 16-bit output ports; port n occupies bits [16n+15:16n]
in_port  in  64  4 x 16-bit asynchronous input ports
irq  out  1  timer interrupt request, level

Behaviour:
- Hit: addr[15:4] == BASE[15:4]. An access without a hit is ignored (rvalid stays 0).
- Register map by offset (addr[3:0]):
  - 0-3: OUT0-3, read/write.
  - 4-7: IN0-3, read-only; value is the 2-flop synchronized copy of in_port.
  - 8: RELOAD, read/write.
  - 9: CTRL, read/write. bit0 = EN, bit1 = IE, bit15 = EXP. Writing 1 to bit15 clears EXP; writing 0 leaves it unchanged. Other bits read 0.
  - 10: COUNT, read-only.
  - 11-15: reserved; read 0, writes ignored.
- Writes take effect at the clk edge where wr_en is sampled. Writes to read-only or reserved offsets have no effect.
- Reads: 1-cycle latency. rd_en+hit at edge N gives rdata and rvalid=1 during cycle N+1. rvalid is 0 otherwise. rdata holds its last value when rvalid=0.
- wr_en and rd_en asserted together: the write commits and the read returns the pre-write value.
- Timer prescaler: counter from 0 to PRESCALE-1; it runs only while EN=1 and is cleared while EN=0. A tick occurs on wrap.
- Timer count on tick:
  - COUNT != 0: COUNT decrements.
  - COUNT == 0: COUNT <= RELOAD and EXP <= 1 (auto-reload).
- A write to RELOAD also loads COUNT <= wdata and clears the prescaler.
- Tick and CTRL write clearing EXP in the same cycle: set wins, EXP = 1.
- Setting EN from 0 to 1 does not load COUNT; it resumes from its current value.
- irq = EXP & IE, combinational from registers.
- Reset values: all registers, out_port, rdata, COUNT, prescaler and synchronizer flops = 0; rvalid = 0; irq = 0.
- Reset asserted mid-access or mid-count: all state clears immediately. The first access after release behaves normally.

Optional Feature:
IO_PERIPH_TIMER_EN.
- Defined: timer, offsets 8-10 and irq behave as specified above.
- Undefined: no timer or prescaler logic is built. Offsets 8-10 read 0, writes to them are ignored, and irq is tied to 0.

Decomposition:
- Shared package (cpu_pkg): offset constants (OFF_OUT0..OFF_COUNT), CTRL bit indices (CTRL_EN = 0, CTRL_IE = 1, CTRL_EXP = 15), and default BASE.
- One sub-module, io_timer: prescaler, COUNT, RELOAD and EXP, with load, clear-EXP and CTRL inputs.
- Bus decode, port registers and synchronizers stay in io_periph.

Test Plan:
1. Reset then read offsets 0-10 -> each read has rvalid one cycle after rd_en, and rdata = 0.
2. Write 16'hA5A5 to 16'hFF02 -> out_port[47:32] = A5A5 the next cycle; a read of FF02 returns A5A5. Write to 16'hFE02 -> no port change; a read of FE02 gives no rvalid.
3. Drive in_port[15:0] = 16'h1234 -> a read of FF04 issued 2 cycles later returns 1234. A write to FF04 does not alter it.
4. PRESCALE=16: write RELOAD = 3, then CTRL = 16'h0003 -> COUNT steps 3,2,1,0 every 16 cycles. On the following tick, EXP = 1 and irq = 1 and COUNT = 3. Write CTRL = 16'h8003 -> irq = 0.
5. Timer with RELOAD=0: issue the EXP clear on the same cycle as an expiring tick -> EXP remains 1. Separately, rd_en+wr_en to FF00 with wdata=7 while OUT0=5 -> rdata=5, then OUT0=7.
6. Pull reset low mid-count with EXP=1 -> irq, COUNT, out_port and rvalid = 0 immediately. Compiled without IO_PERIPH_TIMER_EN -> FF08-FF0A read 0 and irq stays 0.
